// File: rtl/cache_way_ctrl_pkg.sv
// Shared types and constants for the 8-way cache way controller.
package cache_way_ctrl_pkg;

  localparam int WAYS   = 8;
  localparam int WAY_W  = 3;
  localparam int PLRU_W = WAYS - 1;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    RESP
  } state_e;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] vec);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = WAY_W'(i);
    end
    return idx;
  endfunction

  // True when more than one bit of the vector is set.
  function automatic logic multi_bit(input logic [WAYS-1:0] vec);
    return (vec & (vec - WAYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/cache_way_ctrl_if.sv
// Request / lookup / memory signal bundle between the CPU side and the controller.
interface cache_way_ctrl_if
  import cache_way_ctrl_pkg::*;
#(
  parameter int INDEX_W = 6
);

  // CPU request handshake
  logic               req_valid;
  logic               req_ready;
  logic [INDEX_W-1:0] req_index;

  // Tag-array results for the captured set
  logic [WAYS-1:0]    hit_vec;
  logic [WAYS-1:0]    valid_vec;
  logic [WAYS-1:0]    dirty_vec;

  // Line mux control
  logic [WAY_W-1:0]   sel;
  logic               mux_en;

  // Memory side
  logic               mem_req;
  logic               mem_wb;
  logic               mem_ack;
  logic               fill_we;

  // Response and status
  logic               resp_valid;
  logic               resp_hit;
  logic               err;

  // Requester / environment side
  modport master (
    output req_valid, req_index, hit_vec, valid_vec, dirty_vec, mem_ack,
    input  req_ready, sel, mux_en, mem_req, mem_wb, fill_we,
           resp_valid, resp_hit, err
  );

  // Controller side
  modport slave (
    input  req_valid, req_index, hit_vec, valid_vec, dirty_vec, mem_ack,
    output req_ready, sel, mux_en, mem_req, mem_wb, fill_we,
           resp_valid, resp_hit, err
  );

endinterface

// File: rtl/cache_way_ctrl_plru_tree8.sv
// Combinational victim walk and access update for one 7-node tree-PLRU.
// Node 0 is the root, nodes 1-2 the middle level, nodes 3-6 the leaves' parents;
// a node value of 0 steers the victim toward the lower half of its subtree.
module plru_tree8
  import cache_way_ctrl_pkg::*;
(
  input  logic [PLRU_W-1:0] tree_i,
  input  logic [WAY_W-1:0]  way_i,
  output logic [WAY_W-1:0]  victim_o,
  output logic [PLRU_W-1:0] tree_o
);

  logic       v2;
  logic       v1;
  logic       v0;
  logic [2:0] mid_node;
  logic [2:0] low_node;
  logic [2:0] upd_mid;
  logic [2:0] upd_low;

  // Walk from the root following node values to find the victim way.
  always_comb begin
    v2       = tree_i[0];
    mid_node = 3'd1 + {2'b00, v2};
    v1       = tree_i[mid_node];
    low_node = 3'd3 + {1'b0, v2, v1};
    v0       = tree_i[low_node];
    victim_o = {v2, v1, v0};
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    upd_mid          = 3'd1 + {2'b00, way_i[2]};
    upd_low          = 3'd3 + {1'b0, way_i[2:1]};
    tree_o           = tree_i;
    tree_o[0]        = ~way_i[2];
    tree_o[upd_mid]  = ~way_i[1];
    tree_o[upd_low]  = ~way_i[0];
  end

endmodule

// File: rtl/cache_way_ctrl.sv
// Cache way controller: hit detection, victim choice (invalid-first then
// tree-PLRU), optional dirty writeback, line fill and a one-cycle response.
module cache_way_ctrl
  import cache_way_ctrl_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  cache_way_ctrl_if.slave  bus
);

  state_e             state_q,   state_d;
  logic [INDEX_W-1:0] index_q,   index_d;
  logic [WAY_W-1:0]   way_q,     way_d;
  logic               hit_q,     hit_d;
  logic               wb_done_q, wb_done_d;
  logic               err_q,     err_d;

  // One PLRU tree per set; held in flops because reset clears every tree.
  logic [PLRU_W-1:0]  plru_q [NUM_SETS];

  logic [PLRU_W-1:0]  cur_tree;
  logic [PLRU_W-1:0]  upd_tree;
  logic [WAY_W-1:0]   upd_way;
  logic [WAY_W-1:0]   plru_victim;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim_way;
  logic               any_invalid;
  logic               plru_we;

  logic               req_ready_c;
  logic [WAY_W-1:0]   sel_c;
  logic               mux_en_c;
  logic               mem_req_c;
  logic               mem_wb_c;
  logic               fill_we_c;
  logic               resp_valid_c;
  logic               resp_hit_c;

  assign cur_tree    = plru_q[index_q];
  assign hit_way     = lowest_set(bus.hit_vec);
  assign any_invalid = (~bus.valid_vec) != '0;
  assign victim_way  = any_invalid ? lowest_set(~bus.valid_vec) : plru_victim;
  // A LOOKUP update records the hit way; a FILL update records the stored victim.
  assign upd_way     = (state_q == LOOKUP) ? hit_way : way_q;

  plru_tree8 u_plru (
    .tree_i   (cur_tree),
    .way_i    (upd_way),
    .victim_o (plru_victim),
    .tree_o   (upd_tree)
  );

  // Next-state and Moore/Mealy output decode; everything defaults to idle values.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    way_d        = way_q;
    hit_d        = hit_q;
    wb_done_d    = wb_done_q;
    err_d        = err_q;
    plru_we      = 1'b0;
    req_ready_c  = 1'b0;
    sel_c        = '0;
    mux_en_c     = 1'b0;
    mem_req_c    = 1'b0;
    mem_wb_c     = 1'b0;
    fill_we_c    = 1'b0;
    resp_valid_c = 1'b0;
    resp_hit_c   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          index_d = bus.req_index;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (bus.hit_vec != '0) begin
          way_d   = hit_way;
          hit_d   = 1'b1;
          plru_we = 1'b1;
          if (multi_bit(bus.hit_vec)) err_d = 1'b1;
          state_d = RESP;
        end else begin
          way_d     = victim_way;
          hit_d     = 1'b0;
          wb_done_d = 1'b0;
          if (bus.valid_vec[victim_way] && bus.dirty_vec[victim_way]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end

      WRITEBACK: begin
        // After the ack, one extra cycle with mem_req low separates the
        // writeback from the fill request.
        sel_c = way_q;
        if (!wb_done_q) begin
          mem_req_c = 1'b1;
          mem_wb_c  = 1'b1;
          mux_en_c  = 1'b1;
          if (bus.mem_ack) wb_done_d = 1'b1;
        end else begin
          wb_done_d = 1'b0;
          state_d   = FILL;
        end
      end

      FILL: begin
        sel_c     = way_q;
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          fill_we_c = 1'b1;
          plru_we   = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        sel_c        = way_q;
        mux_en_c     = 1'b1;
        resp_valid_c = 1'b1;
        resp_hit_c   = hit_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Controller state registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      way_q     <= '0;
      hit_q     <= 1'b0;
      wb_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      way_q     <= way_d;
      hit_q     <= hit_d;
      wb_done_q <= wb_done_d;
      err_q     <= err_d;
    end
  end

  // PLRU tree storage: cleared on reset, written back for the captured set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[index_q] <= upd_tree;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.sel        = sel_c;
  assign bus.mux_en     = mux_en_c;
  assign bus.mem_req    = mem_req_c;
  assign bus.mem_wb     = mem_wb_c;
  assign bus.fill_we    = fill_we_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_hit   = resp_hit_c;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed scenario bench for cache_way_ctrl; one output snapshot compared per cycle.
module tb_cache_way_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  cache_way_ctrl_if #(.INDEX_W(6)) bus ();

  cache_way_ctrl #(.NUM_SETS(64), .INDEX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [5:0]  idx;
    logic [7:0]  hit;
    logic [7:0]  vld;
    logic [7:0]  drt;
    logic        ack;
    logic [10:0] exp;
  } vec_t;

  // Snapshot layout: {req_ready, sel[2:0], mux_en, mem_req, mem_wb, fill_we, resp_valid, resp_hit, err}
  function automatic logic [10:0] obs();
    return {bus.req_ready, bus.sel, bus.mux_en, bus.mem_req, bus.mem_wb,
            bus.fill_we, bus.resp_valid, bus.resp_hit, bus.err};
  endfunction

  function automatic logic [10:0] ex(input logic rdy, input logic [2:0] s, input logic men,
                                     input logic mreq, input logic mwb, input logic fwe,
                                     input logic rv, input logic rh, input logic er);
    return {rdy, s, men, mreq, mwb, fwe, rv, rh, er};
  endfunction

  function automatic logic [10:0] e_idle(input logic er);
    return ex(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er);
  endfunction
  function automatic logic [10:0] e_lookup(input logic er);
    return ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er);
  endfunction
  function automatic logic [10:0] e_wb(input logic [2:0] s, input logic er);
    return ex(1'b0, s, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, er);
  endfunction
  function automatic logic [10:0] e_gap(input logic [2:0] s, input logic er);
    return ex(1'b0, s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er);
  endfunction
  function automatic logic [10:0] e_fill(input logic [2:0] s, input logic fwe, input logic er);
    return ex(1'b0, s, 1'b0, 1'b1, 1'b0, fwe, 1'b0, 1'b0, er);
  endfunction
  function automatic logic [10:0] e_resp(input logic [2:0] s, input logic rh, input logic er);
    return ex(1'b0, s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rh, er);
  endfunction

  function automatic vec_t mk(input logic r, input logic rv, input logic [5:0] idx,
                              input logic [7:0] hit, input logic [7:0] vld, input logic [7:0] drt,
                              input logic ack, input logic [10:0] exp);
    vec_t v;
    v.rst = r; v.rv = rv; v.idx = idx; v.hit = hit;
    v.vld = vld; v.drt = drt; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst           = v.rst;
    bus.req_valid = v.rv;
    bus.req_index = v.idx;
    bus.hit_vec   = v.hit;
    bus.valid_vec = v.vld;
    bus.dirty_vec = v.drt;
    bus.mem_ack   = v.ack;
  endtask

  task automatic test_reset();
    vec_t q[$];
    q.push_back(mk(1, 1, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL reset[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("reset[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  // Miss on set 5 with no valid ways: fill straight into way 0.
  task automatic test_miss_fill();
    vec_t q[$];
    q.push_back(mk(0, 1, 6'd5, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd5, 8'h00, 8'h00, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_fill(3'd0, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 1, e_fill(3'd0, 1, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd0, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL miss_fill[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("miss_fill[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  // Hit way 0 of set 3 steers the tree so the following miss evicts way 4.
  task automatic test_plru_victim();
    vec_t q[$];
    q.push_back(mk(0, 1, 6'd3, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd3, 8'h01, 8'hFF, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd0, 1, 0)));
    q.push_back(mk(0, 1, 6'd3, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd3, 8'h00, 8'hFF, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 1, e_fill(3'd4, 1, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd4, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL plru_victim[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("plru_victim[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  // Dirty victim (way 2 of set 3) with the writeback ack delayed 3 cycles.
  task automatic test_writeback();
    vec_t q[$];
    q.push_back(mk(0, 1, 6'd3, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd3, 8'h00, 8'hFF, 8'hFF, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_wb(3'd2, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_wb(3'd2, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_wb(3'd2, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 1, e_wb(3'd2, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_gap(3'd2, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_fill(3'd2, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 1, e_fill(3'd2, 1, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd2, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL writeback[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("writeback[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  // Two back-to-back hits, then an invalid-way miss acked in its first FILL cycle.
  task automatic test_back_to_back();
    vec_t q[$];
    q.push_back(mk(0, 1, 6'd9, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd9, 8'h80, 8'hFF, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd7, 1, 0)));
    q.push_back(mk(0, 1, 6'd9, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd9, 8'h10, 8'hFF, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd4, 1, 0)));
    q.push_back(mk(0, 1, 6'd9, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd9, 8'h00, 8'hEF, 8'hFF, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 1, e_fill(3'd4, 1, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd4, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL back_to_back[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("back_to_back[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  // hit_vec=24h picks way 2 and raises a sticky err.
  task automatic test_multihit();
    vec_t q[$];
    q.push_back(mk(0, 1, 6'd7, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd7, 8'h24, 8'hFF, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd2, 1, 1)));
    q.push_back(mk(0, 1, 6'd7, 8'h00, 8'h00, 8'h00, 0, e_idle(1)));
    q.push_back(mk(0, 0, 6'd7, 8'h01, 8'hFF, 8'h00, 0, e_lookup(1)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd0, 1, 1)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(1)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL multihit[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("multihit[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  // Reset in the middle of a writeback of way 6; the next miss on set 3 evicts way 0.
  task automatic test_rst_during_wb();
    vec_t q[$];
    q.push_back(mk(0, 1, 6'd3, 8'h00, 8'h00, 8'h00, 0, e_idle(1)));
    q.push_back(mk(0, 0, 6'd3, 8'h00, 8'hFF, 8'hFF, 0, e_lookup(1)));
    q.push_back(mk(1, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_wb(3'd6, 1)));
    q.push_back(mk(0, 1, 6'd3, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    q.push_back(mk(0, 0, 6'd3, 8'h00, 8'hFF, 8'h00, 0, e_lookup(0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 1, e_fill(3'd0, 1, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_resp(3'd0, 0, 0)));
    q.push_back(mk(0, 0, 6'd0, 8'h00, 8'h00, 8'h00, 0, e_idle(0)));
    foreach (q[k]) begin
      apply(q[k]); #1;
      n_cmp++;
      if (obs() !== q[k].exp) begin
        n_bad++;
        $display("FAIL rst_during_wb[%0d] got %b want %b", k, obs(), q[k].exp);
      end
      $display("rst_during_wb[%0d] out=%b", k, obs());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_index = '0;
    bus.hit_vec   = '0;
    bus.valid_vec = '0;
    bus.dirty_vec = '0;
    bus.mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_miss_fill();
    test_plru_victim();
    test_writeback();
    test_back_to_back();
    test_multihit();
    test_rst_during_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no_finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_way_ctrl.md
CACHE_WAY_CTRL -- requirements
Module: cache_way_ctrl

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64, number of sets; power of two.
REQ-002 SHALL have parameter INDEX_W, default 6, equal to log2(NUM_SETS).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  CPU access request.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_index  in  INDEX_W  set index, captured on acceptance.
REQ-009 hit_vec  in  8  per-way tag match for the captured set; sampled in LOOKUP.
REQ-010 valid_vec  in  8  per-way valid bits for the captured set; sampled in LOOKUP.
REQ-011 dirty_vec  in  8  per-way dirty bits for the captured set; sampled in LOOKUP.
REQ-012 sel  out  3  way select to the 8:1 512-bit line mux.
REQ-013 mux_en  out  1  enable to the line mux.
REQ-014 mem_req  out  1  memory transaction request; held high until mem_ack.
REQ-015 mem_wb  out  1  qualifies mem_req: 1 = writeback of the victim line, 0 = line fill.
REQ-016 mem_ack  in  1  memory completion; may be high in the first mem_req cycle.
REQ-017 fill_we  out  1  one-cycle write strobe for the fill line into way sel.
REQ-018 resp_valid  out  1  one-cycle response pulse.
REQ-019 resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = miss serviced.
REQ-020 err  out  1  sticky multi-hit error flag.

Function
REQ-021 The FSM SHALL have five states: IDLE, LOOKUP, WRITEBACK, FILL and RESP.
REQ-022 IDLE SHALL drive req_ready=1 and mux_en=0, and on acceptance SHALL capture the index and go to LOOKUP.
REQ-023 In LOOKUP, a nonzero hit_vec SHALL select the lowest set bit as way, update the PLRU and go to RESP with resp_hit=1.
REQ-024 In LOOKUP, hit_vec with more than one bit set SHALL additionally set err; err stays set until rst.
REQ-025 In LOOKUP, hit_vec=0 SHALL select a victim: the lowest-index way with valid_vec=0, else the PLRU victim.
REQ-026 On a miss, the next state SHALL be WRITEBACK if the victim is valid and dirty, else FILL.
REQ-027 WRITEBACK SHALL drive mem_req=1, mem_wb=1, sel=victim and mux_en=1, and SHALL go to FILL in the cycle after mem_ack.
REQ-028 FILL SHALL drive mem_req=1, mem_wb=0, sel=victim and mux_en=0.
REQ-029 In the mem_ack cycle, FILL SHALL pulse fill_we, update the PLRU with the victim and go to RESP with resp_hit=0.
REQ-030 mem_req SHALL deassert for at least one cycle between the writeback and the fill.
REQ-031 RESP SHALL drive resp_valid=1, sel=way and mux_en=1 for one cycle, then go to IDLE; req_ready=0 in RESP.
REQ-032 Hit latency SHALL be: accept in cycle 0, resp_valid in cycle 2, next accept in cycle 3.
REQ-033 PLRU state SHALL be one 7-bit tree per set (node 0 = root, nodes 1-2 = level 1, nodes 3-6 = level 2); a node value of 0 points the victim toward its lower half.
REQ-034 PLRU update on access to way w SHALL set node0=~w[2], node(1+w[2])=~w[1] and node(3+w[2:1])=~w[0]; all other nodes are unchanged.
REQ-035 The PLRU victim SHALL be found by walking the tree from the root: v[2]=node0, v[1]=node(1+v[2]), v[0]=node(3+v[2:1]).
REQ-036 The PLRU SHALL update only on a LOOKUP hit and on FILL completion.

Reset
REQ-037 rst SHALL force state IDLE, sel=0, and clear mux_en, mem_req, mem_wb, fill_we, resp_valid, resp_hit and err.
REQ-038 rst SHALL clear all PLRU trees to 0 and abandon any in-flight transaction, with mem_req low in the cycle after rst.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, WAYS=8 and WAY_W=3.
REQ-040 One sub-module, plru_tree8, SHALL implement the combinational victim and update logic for one 7-bit tree.

Verification
REQ-041 Scenario: after rst, a miss on set 5 with valid_vec=0 -> FILL, sel=0, fill_we pulse, resp_valid with resp_hit=0, no writeback.
REQ-042 Scenario: with valid_vec=FF, dirty_vec=00 and all PLRU 0, a hit on way 0 of set 3, then a miss on set 3 -> victim way 4, fill only.
REQ-043 Scenario: a miss with valid_vec=FF, dirty_vec=FF and mem_ack delayed 3 cycles -> mem_wb=1 for 4 cycles with sel=victim and mux_en=1, mem_req low 1 cycle, then the fill.
REQ-044 Scenario: hit_vec=24 (hex) -> sel=2, resp_hit=1, err=1 and still 1 after the next request.
REQ-045 Scenario: back-to-back hits -> resp_valid every 3 cycles; mem_ack asserted together with mem_req -> single-cycle FILL.
REQ-046 Scenario: rst during WRITEBACK -> mem_req=0 the next cycle, state IDLE, and the next miss picks victim way 0.
